// File: rtl/term_pkg.sv
// Shared types and character constants for the terminal write controller.
// The ECHO state exists only when TERM_ECHO_EN is defined.
package term_pkg;

  localparam int DEFAULT_COLS = 32;
  localparam int DEFAULT_ROWS = 4;

  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam logic [7:0] CHAR_BS        = 8'h08;
  localparam logic [7:0] CHAR_FF        = 8'h0C;
  localparam logic [7:0] CHAR_BLANK     = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ADV,
    ST_CLEAR
`ifdef TERM_ECHO_EN
    , ST_ECHO
`endif
  } state_e;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_ADVANCE,
    OP_NEWLINE,
    OP_BACK,
    OP_HOME
  } cursor_op_e;

  function automatic logic isPrintable(input logic [7:0] c);
    return (c >= CHAR_PRINT_MIN) && (c <= CHAR_PRINT_MAX);
  endfunction

endpackage

// File: rtl/term_write_ctrl_if.sv
// Request, character-RAM and echo signals between the UART side and term_write_ctrl.
// The controller connects through the slave modport.
interface term_write_ctrl_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 5
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             clr_req;
  logic             ram_we;
  logic [ROW_W-1:0] ram_row;
  logic [COL_W-1:0] ram_col;
  logic [7:0]       ram_wdata;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             busy;
  logic             overrun;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;

  modport master (
    output rx_valid, rx_data, clr_req, tx_busy,
    input  ram_we, ram_row, ram_col, ram_wdata, cur_row, cur_col,
           busy, overrun, tx_start, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, clr_req, tx_busy,
    output ram_we, ram_row, ram_col, ram_wdata, cur_row, cur_col,
           busy, overrun, tx_start, tx_data
  );
endinterface

// File: rtl/term_cursor.sv
// Cursor row/column register; all moves wrap modulo COLS and ROWS.
module term_cursor
  import term_pkg::*;
#(
  parameter int COLS  = DEFAULT_COLS,
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  cursor_op_e       op_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // COLS is a power of two, so the last column is all ones and +1 wraps to zero.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    unique case (op_i)
      OP_ADVANCE: begin
        col_d = col_q + 1'b1;
        if (&col_q) row_d = row_q + 1'b1;
      end
      OP_NEWLINE: begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end
      OP_BACK:  col_d = col_q - 1'b1;
      OP_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/term_write_ctrl.sv
// Sequences all writes into the VGA text RAM: printable bytes, CR/LF, backspace, clear sweeps.
// Define TERM_ECHO_EN to echo each accepted byte back through the UART transmitter.
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS,
  parameter int ROWS = DEFAULT_ROWS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  term_write_ctrl_if.slave   bus
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int SWEEP_W = ROW_W + COL_W;

  state_e             state_q;
  cursor_op_e         advOp_q;
  cursor_op_e         curOp;
  logic               ramWe_q;
  logic [ROW_W-1:0]   ramRow_q;
  logic [COL_W-1:0]   ramCol_q;
  logic [7:0]         ramWdata_q;
  logic               busy_q;
  logic               overrun_q;
  logic               ovrPend_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic [ROW_W-1:0]   curRow;
  logic [COL_W-1:0]   curCol;
  logic               anyReq;
  logic               isClear;

  assign anyReq  = bus.rx_valid | bus.clr_req;
  assign isClear = bus.clr_req | (bus.rx_valid && (bus.rx_data == CHAR_FF));

  term_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .op_i   (curOp),
    .row_o  (curRow),
    .col_o  (curCol)
  );

  // Backspace steps back immediately so its blank lands on the new position.
  always_comb begin
    curOp = OP_HOLD;
    unique case (state_q)
      ST_IDLE:
        if (bus.rx_valid && !isClear && (bus.rx_data == CHAR_BS) && (curCol != '0))
          curOp = OP_BACK;
      ST_ADV:   curOp = advOp_q;
      ST_CLEAR: if (sweep_q == '0) curOp = OP_HOME;
      default: ;
    endcase
  end

`ifdef TERM_ECHO_EN
  logic       txStart_q;
  logic [7:0] txData_q;
  logic [7:0] echoByte_q;
  logic       echoSent_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      advOp_q    <= OP_HOLD;
      ramWe_q    <= 1'b0;
      ramRow_q   <= '0;
      ramCol_q   <= '0;
      ramWdata_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ovrPend_q  <= 1'b0;
      sweep_q    <= '0;
`ifdef TERM_ECHO_EN
      txStart_q  <= 1'b0;
      txData_q   <= '0;
      echoByte_q <= '0;
      echoSent_q <= 1'b0;
`endif
    end else begin
      ramWe_q <= 1'b0;
`ifdef TERM_ECHO_EN
      txStart_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (isClear) begin
            state_q    <= ST_CLEAR;
            busy_q     <= 1'b1;
            ramWe_q    <= 1'b1;
            ramRow_q   <= '0;
            ramCol_q   <= '0;
            ramWdata_q <= CHAR_BLANK;
            sweep_q    <= SWEEP_W'(1);
            overrun_q  <= 1'b0;
            ovrPend_q  <= bus.clr_req & bus.rx_valid;
          end else if (bus.rx_valid) begin
`ifdef TERM_ECHO_EN
            echoByte_q <= bus.rx_data;
`endif
            if (isPrintable(bus.rx_data)) begin
              state_q    <= ST_WRITE;
              busy_q     <= 1'b1;
              ramWe_q    <= 1'b1;
              ramRow_q   <= curRow;
              ramCol_q   <= curCol;
              ramWdata_q <= bus.rx_data;
              advOp_q    <= OP_ADVANCE;
            end else if ((bus.rx_data == CHAR_CR) || (bus.rx_data == CHAR_LF)) begin
              state_q <= ST_ADV;
              busy_q  <= 1'b1;
              advOp_q <= OP_NEWLINE;
            end else if ((bus.rx_data == CHAR_BS) && (curCol != '0)) begin
              state_q    <= ST_WRITE;
              busy_q     <= 1'b1;
              ramWe_q    <= 1'b1;
              ramRow_q   <= curRow;
              ramCol_q   <= curCol - 1'b1;
              ramWdata_q <= CHAR_BLANK;
              advOp_q    <= OP_HOLD;
            end
          end
        end
        ST_WRITE: begin
          state_q <= ST_ADV;
          if (anyReq) overrun_q <= 1'b1;
        end
        ST_ADV: begin
`ifdef TERM_ECHO_EN
          state_q    <= ST_ECHO;
          echoSent_q <= 1'b0;
`else
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`endif
          if (anyReq) overrun_q <= 1'b1;
        end
        // Requests during the sweep must survive the sweep's own overrun clear.
        ST_CLEAR: begin
          if (sweep_q != '0) begin
            ramWe_q                <= 1'b1;
            {ramRow_q, ramCol_q}   <= sweep_q;
            ramWdata_q             <= CHAR_BLANK;
            sweep_q                <= sweep_q + 1'b1;
            if (anyReq) begin
              overrun_q <= 1'b1;
              ovrPend_q <= 1'b1;
            end
          end else begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            overrun_q <= ovrPend_q | anyReq;
            ovrPend_q <= 1'b0;
          end
        end
`ifdef TERM_ECHO_EN
        ST_ECHO: begin
          if (echoSent_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!bus.tx_busy) begin
            txStart_q  <= 1'b1;
            txData_q   <= echoByte_q;
            echoSent_q <= 1'b1;
          end
          if (anyReq) overrun_q <= 1'b1;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_we    = ramWe_q;
  assign bus.ram_row   = ramRow_q;
  assign bus.ram_col   = ramCol_q;
  assign bus.ram_wdata = ramWdata_q;
  assign bus.cur_row   = curRow;
  assign bus.cur_col   = curCol;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

`ifdef TERM_ECHO_EN
  assign bus.tx_start = txStart_q;
  assign bus.tx_data  = txData_q;
`else
  logic unusedTxBusy;
  assign unusedTxBusy = bus.tx_busy;
  assign bus.tx_start = 1'b0;
  assign bus.tx_data  = '0;
`endif

endmodule
